// File: rtl/board_renderer.sv
// Tic-tac-toe board overlay: maps the VGA scan position onto a 3x3 grid and paints
// grid lines, a blinking cursor and X/O marks through a two-stage pixel pipeline.
module board_renderer #(
  parameter int unsigned GRID_X0      = 80,
  parameter int unsigned CELL         = 160,
  parameter int unsigned LINE_W       = 4,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [17:0] board,
  input  logic [3:0]  cursor,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_tick
);

  localparam int unsigned BOARD_PX = 3 * CELL;
  localparam int unsigned BLINK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned MARK_IN  = CELL * 3 / 20;
  localparam int unsigned R_IN     = CELL * 3 / 10;
  localparam int unsigned R_OUT    = CELL * 7 / 20;

  localparam logic [9:0]  X_LO     = 10'(GRID_X0);
  localparam logic [9:0]  X_HI     = 10'(GRID_X0 + BOARD_PX);
  localparam logic [9:0]  Y_HI     = 10'(BOARD_PX);
  localparam logic [9:0]  C1       = 10'(CELL);
  localparam logic [9:0]  C2       = 10'(2 * CELL);
  localparam logic [9:0]  VBLANK_Y = 10'd480;
  localparam logic [7:0]  GRID_LO  = 8'(LINE_W / 2);
  localparam logic [7:0]  GRID_HI  = 8'(CELL - LINE_W / 2);
  localparam logic [7:0]  CUR_LO   = 8'(LINE_W);
  localparam logic [7:0]  CUR_HI   = 8'(CELL - LINE_W);
  localparam logic [7:0]  MARK_LO  = 8'(MARK_IN);
  localparam logic [7:0]  MARK_HI  = 8'(CELL - MARK_IN);
  localparam logic [7:0]  STROKE   = 8'd3;
  localparam logic [8:0]  DIAG     = 9'(CELL - 1);
  localparam logic [8:0]  CENTER   = 9'(CELL / 2);
  localparam logic [13:0] RING_IN2 = 14'(R_IN * R_IN);
  localparam logic [13:0] RING_OUT2 = 14'(R_OUT * R_OUT);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_CURSOR = 12'hFF0;
  localparam logic [11:0] RGB_GRID   = 12'hFFF;
  localparam logic [11:0] RGB_X      = 12'hF00;
  localparam logic [11:0] RGB_O      = 12'h00F;

  // stage-1 decode
  logic [9:0] bx, xoff, yoff;
  logic [1:0] col_d, row_d;
  logic [7:0] lx_d, ly_d;
  logic       in_board_d;

  // stage-1 registers
  logic       video_q, in_board_q, hs1_q, vs1_q;
  logic [1:0] col_q, row_q;
  logic [7:0] lx_q, ly_q;

  // stage-2 / output registers
  logic [11:0] rgb_q, rgb_d;
  logic        hs2_q, vs2_q, frame_tick_q;

  // frame-stable shadows and blink state
  logic [17:0]        board_sh_q;
  logic [3:0]         cursor_sh_q;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic               latch_c;

  // stage-2 classification
  logic [3:0]  idx;
  logic [1:0]  code;
  logic [7:0]  ad_main, adx, ady;
  logic [8:0]  sum, ad_anti, dx, dy;
  logic [13:0] r2;
  logic        grid_hit, cur_hit, x_hit, o_hit;

  assign latch_c = p_tick && (x == 10'd0) && (y == VBLANK_Y);

  // Cell/local-coordinate decode by range compare instead of division
  always_comb begin
    bx         = x - X_LO;
    in_board_d = (x >= X_LO) && (x < X_HI) && (y < Y_HI);
    if (bx < C1) begin
      col_d = 2'd0;
      xoff  = 10'd0;
    end else if (bx < C2) begin
      col_d = 2'd1;
      xoff  = C1;
    end else begin
      col_d = 2'd2;
      xoff  = C2;
    end
    if (y < C1) begin
      row_d = 2'd0;
      yoff  = 10'd0;
    end else if (y < C2) begin
      row_d = 2'd1;
      yoff  = C1;
    end else begin
      row_d = 2'd2;
      yoff  = C2;
    end
    lx_d = 8'(bx - xoff);
    ly_d = 8'(y - yoff);
  end

  // Pixel classification and colour priority
  always_comb begin
    idx     = 4'(row_q) * 4'd3 + 4'(col_q);
    code    = 2'(board_sh_q >> {idx, 1'b0});
    ad_main = (lx_q >= ly_q) ? (lx_q - ly_q) : (ly_q - lx_q);
    sum     = 9'(lx_q) + 9'(ly_q);
    ad_anti = (sum >= DIAG) ? (sum - DIAG) : (DIAG - sum);
    dx      = 9'(lx_q) - CENTER;
    dy      = 9'(ly_q) - CENTER;
    adx     = dx[8] ? 8'(-dx) : 8'(dx);
    ady     = dy[8] ? 8'(-dy) : 8'(dy);
    r2      = 14'(adx) * 14'(adx) + 14'(ady) * 14'(ady);

    grid_hit = ((col_q != 2'd0) && (lx_q < GRID_LO)) || ((col_q != 2'd2) && (lx_q >= GRID_HI)) ||
               ((row_q != 2'd0) && (ly_q < GRID_LO)) || ((row_q != 2'd2) && (ly_q >= GRID_HI));
    cur_hit  = (cursor_sh_q == idx) && blink_on_q &&
               ((lx_q < CUR_LO) || (lx_q >= CUR_HI) || (ly_q < CUR_LO) || (ly_q >= CUR_HI));
    x_hit    = (code == 2'b01) &&
               (lx_q >= MARK_LO) && (lx_q < MARK_HI) && (ly_q >= MARK_LO) && (ly_q < MARK_HI) &&
               ((ad_main <= STROKE) || (ad_anti <= 9'(STROKE)));
    o_hit    = (code == 2'b10) && (r2 >= RING_IN2) && (r2 <= RING_OUT2);

    rgb_d = RGB_BLACK;
    if (video_q && in_board_q) begin
      if (cur_hit)       rgb_d = RGB_CURSOR;
      else if (grid_hit) rgb_d = RGB_GRID;
      else if (x_hit)    rgb_d = RGB_X;
      else if (o_hit)    rgb_d = RGB_O;
    end
  end

  // Blink phase advances once per latched frame
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (latch_c) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      video_q     <= 1'b0;
      in_board_q  <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      lx_q        <= 8'd0;
      ly_q        <= 8'd0;
      rgb_q       <= RGB_BLACK;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      board_sh_q  <= 18'd0;
      cursor_sh_q <= 4'd15;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (p_tick) begin
      video_q     <= video_on;
      in_board_q  <= in_board_d;
      hs1_q       <= hsync_in;
      vs1_q       <= vsync_in;
      col_q       <= col_d;
      row_q       <= row_d;
      lx_q        <= lx_d;
      ly_q        <= ly_d;
      rgb_q       <= rgb_d;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      if (latch_c) begin
        board_sh_q  <= board;
        cursor_sh_q <= cursor;
      end
    end
  end

  // Single-clk pulse, so it is not held across the idle half of the pixel period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_tick_q <= 1'b0;
    else       frame_tick_q <= latch_c;
  end

  assign rgb        = rgb_q;
  assign hsync_out  = hs2_q;
  assign vsync_out  = vs2_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/board_renderer.md
BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- GRID_X0, 80: leftmost board column in screen x.
- CELL, 160: cell edge length in pixels; board is 3x3 cells, 480x480.
- LINE_W, 4: grid-line and cursor-border thickness in pixels.
- BLINK_FRAMES, 30: frames per cursor blink phase.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- p_tick  in  1  pixel enable from the sync generator; high every 2nd clk.
- video_on  in  1  pixel is inside the 640x480 display area.
- hsync_in  in  1  horizontal sync from the sync generator; polarity is passed through.
- vsync_in  in  1  vertical sync from the sync generator; polarity is passed through.
- x  in  10  current pixel column, 0..799.
- y  in  10  current pixel row, 0..524.
- board  in  18  cell k occupies bits [2k+1:2k], k=0..8, row-major from top-left; 00 empty, 01 X, 10 O, 11 treated as empty.
- cursor  in  4  selected cell 0..8; values 9..15 mean no cursor.
- rgb  out  12  pixel colour, 4 bits each R,G,B.
- hsync_out  out  1  hsync_in delayed to align with rgb.
- vsync_out  out  1  vsync_in delayed to align with rgb.
- frame_tick  out  1  one-clk pulse when the board and cursor inputs are latched.

Function
REQ-003 All state, including pipeline, shadow and blink registers, SHALL update only on clk edges where p_tick=1; otherwise it SHALL hold.
REQ-004 Pipeline SHALL be 2 p_tick-qualified stages:
- S1 registers video_on, in_board, col, row, lx, ly and the syncs.
- S2 registers rgb and the syncs.
- Inputs sampled at pixel tick n appear on the outputs after tick n+2.
REQ-005 in_board SHALL be 1 iff GRID_X0 <= x < GRID_X0+3*CELL and y < 3*CELL.
REQ-006 Cell decode SHALL use magnitude comparisons, not dividers:
- bx = x-GRID_X0; col = 0/1/2 for bx in [0,160), [160,320), [320,480).
- lx = bx-col*CELL, 8 bits unsigned; row and ly are derived from y in the same way.
REQ-007 Shadow registers SHALL copy board and cursor on the p_tick edge where x==0 and y==480 (start of vertical blank). frame_tick SHALL pulse on that same clk. Rendering SHALL use only the shadow copies.
REQ-008 Blink counter:
- Counts frame_tick events over 0..BLINK_FRAMES-1.
- On wrap it returns to 0 and toggles blink_on.
REQ-009 Pixel classes (lx, ly local to the cell):
- grid: (col>0 and lx<LINE_W/2) or (col<2 and lx>=CELL-LINE_W/2), or the same test on row/ly.
- cursor: cell index == shadow cursor, blink_on=1, and (lx<LINE_W or lx>=CELL-LINE_W or ly<LINE_W or ly>=CELL-LINE_W).
- X mark: cell code 01, 24<=lx,ly<136, and (|lx-ly|<=3 or |lx+ly-159|<=3).
- O mark: cell code 10; dx=lx-80 and dy=ly-80 (signed 9-bit); 2304 <= dx*dx+dy*dy <= 3136, with the sum held in 14 bits unsigned.
REQ-010 Colour priority:
- video_on=0 or in_board=0 -> 12'h000.
- otherwise cursor 12'hFF0 > grid 12'hFFF > X 12'hF00 > O 12'h00F > background 12'h000.
REQ-011 Cursor codes 9..15 and cell code 11 SHALL draw nothing; the grid is still drawn.
REQ-012 Input changes to board or cursor mid-frame SHALL NOT affect rendering until the next latch point.

Reset
REQ-013 On reset, without waiting for a clock edge, the block SHALL clear:
- rgb=0, hsync_out=0, vsync_out=0, frame_tick=0.
- all pipeline stages, shadow board=0, shadow cursor=15, blink counter=0.
- blink_on SHALL be set to 1.
REQ-014 After reset deasserts, the first valid rgb SHALL appear 2 pixel ticks later. A reset asserted mid-frame SHALL take effect immediately.

Verification
REQ-015 The bench SHALL cover these directed scenarios:
- Reset mid-line at (x=300, y=100) -> rgb=000, syncs=0 and frame_tick=0 immediately; blink_on=1.
- Empty board, latched: pixel (240,100) -> rgb=FFF after 2 ticks; (300,100) -> 000; (40,100) -> 000; (300,500) -> 000.
- board[9:8]=01 and board[1:0]=10, latched: (320,240) -> F00; (212,80) -> 00F; (160,80) -> 000.
- board changed at y=100 -> the pixel at y=200 still shows the old contents; the new contents appear after frame_tick at (0,480).
- cursor=0 latched: (82,2) -> FF0 for 30 frames, then 000 for 30 frames; cursor=9 -> (82,2)=000 in every frame.
- hsync_in/vsync_in edges -> reproduced on hsync_out/vsync_out exactly 2 pixel ticks later, with polarity unchanged.
